mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have inputs IM_valid (1), IM_mem_en (1), IM_mem_wr (1), IM_reg_en (1), IM_HALT (1), IM_writeregsel (3), IM_alu_result (16, address / ALU value), IM_r2 (16, store data): the EX/MEM register outputs.
REQ-004 SHALL have outputs mem_req (1), mem_wr (1), mem_addr (16), mem_wdata (16), plus inputs mem_ack (1) and mem_rdata (16): the data-memory/cache handshake.
REQ-005 SHALL have outputs stall (1, freezes PC/IF/ID/IE/IM registers), err (1, sticky fault) and registered IW_valid (1), IW_reg_en (1), IW_writeregsel (3), IW_data (16), IW_HALT (1) to writeback.

Function
REQ-006 SHALL implement FSM states IDLE, WAIT, HALTED.
REQ-007 IDLE, IM_valid=1, IM_mem_en=0, IM_HALT=0: SHALL write IW_* next edge (IW_valid=1, IW_data=IM_alu_result, IW_reg_en=IM_reg_en); 1-cycle latency, stall=0.
REQ-008 IDLE, IM_valid=1, IM_mem_en=1: SHALL assert stall combinationally, latch address/IM_r2/IM_mem_wr/IM_writeregsel/IM_reg_en, enter WAIT with mem_req=1 next cycle; IW_valid=0 at that edge.
REQ-009 WAIT: mem_req, mem_wr, mem_addr, mem_wdata SHALL hold stable until mem_ack=1; stall=1 every WAIT cycle without ack.
REQ-010 WAIT with mem_ack=1: stall=0 that cycle; next edge -> IDLE, mem_req=0, IW_valid=1; load: IW_data=mem_rdata, IW_reg_en=latched reg_en; store: IW_reg_en=0.
REQ-011 Minimum memory-op latency SHALL be 2 cycles (acceptance -> ack in first WAIT cycle -> IW write).
REQ-012 mem_ack in IDLE or HALTED SHALL be ignored.
REQ-013 WAIT SHALL run a 4-bit cycle counter cleared on entry; 15 WAIT cycles without ack -> err=1 (sticky), mem_req=0, IDLE, instruction retired as bubble (IW_valid=0).
REQ-014 IDLE, IM_valid=1, IM_HALT=1: SHALL write IW_HALT=1, IW_valid=1 for one cycle, enter HALTED; IM_HALT with IM_valid=0 SHALL be ignored.
REQ-015 HALTED: stall=1, mem_req=0, IW_valid=0, IW_HALT=0, inputs ignored until reset.
REQ-016 IM_valid=0 in IDLE SHALL produce IW_valid=0, IW_reg_en=0 at next edge.
REQ-017 IW_reg_en SHALL never be 1 while IW_valid=0.

Reset
REQ-018 rst=0 at a rising edge SHALL force state IDLE, counter 0, and all outputs 0 (mem_req, mem_wr, mem_addr, mem_wdata, err, IW_*), including mid-WAIT; stall=0 while in reset.
REQ-019 An outstanding request abandoned by reset SHALL not be reissued; a late mem_ack after reset SHALL be ignored.

Configuration
REQ-020 Macro MEM_ALIGN_CHK_EN defined: memory op with IM_alu_result[0]=1 SHALL issue no request, set err=1, stay IDLE, retire as bubble (IW_valid=0), stall=0.
REQ-021 MEM_ALIGN_CHK_EN undefined: no alignment check; mem_addr SHALL equal the latched address unmodified and err only from timeout.

Verification
REQ-022 ALU op, IM_alu_result=16'h1234, IM_reg_en=1, writeregsel=3 -> next edge IW_valid=1, IW_data=16'h1234, IW_writeregsel=3, stall=0.
REQ-023 Load addr 16'h0040, mem_ack after 3 WAIT cycles with mem_rdata=16'hBEEF -> stall high 4 cycles, mem_addr=16'h0040 stable, then IW_data=16'hBEEF, IW_reg_en=1.
REQ-024 Store addr 16'h0010, IM_r2=16'hA5A5, ack in first WAIT cycle -> mem_wr=1, mem_wdata=16'hA5A5, IW_valid=1, IW_reg_en=0, total 2 cycles.
REQ-025 Load with no ack -> after 15 WAIT cycles err=1, mem_req=0, IDLE; next ALU op retires normally, err stays 1.
REQ-026 rst=0 during WAIT cycle 2, then ack -> all outputs 0, IDLE, ack ignored; with MEM_ALIGN_CHK_EN, load addr 16'h0041 -> err=1, no mem_req.
REQ-027 HALT with IM_valid=1 -> IW_HALT=1 one cycle, then stall=1, IW_valid=0 until rst=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage between the EX/MEM register (IM_*) and
// the MEM/WB register (IW_*).
//
// ALU results pass straight through to IW_* with one cycle of latency.
// Loads and stores are issued to the data memory through a req/ack
// handshake. The pipeline is stalled until the access completes or times
// out. A HALT instruction retires once, and the stage then parks until reset.
//
// Ports
//   clk, rst              clock, synchronous active-low reset
//   IM_*                  EX/MEM register outputs (instruction under service)
//   mem_req/wr/addr/wdata request to data memory (registered, stable in WAIT)
//   mem_ack, mem_rdata    response from data memory
//   stall                 freezes PC/IF/ID/IE/IM registers (combinational)
//   err                   sticky fault: access timeout (or misaligned access)
//   IW_*                  registered outputs to writeback
//
// Build option
//   MEM_ALIGN_CHK_EN      when defined, a memory op with an odd address is
//                         refused: no request is issued, err is set and the
//                         instruction retires as a bubble.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | accepting instructions from IM
// WAIT    | memory request outstanding, waiting for mem_ack or timeout
// HALTED  | HALT retired, pipeline frozen until reset

module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        IM_valid,
    input  logic        IM_mem_en,
    input  logic        IM_mem_wr,
    input  logic        IM_reg_en,
    input  logic        IM_HALT,
    input  logic [2:0]  IM_writeregsel,
    input  logic [15:0] IM_alu_result,
    input  logic [15:0] IM_r2,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic        err,
    output logic        IW_valid,
    output logic        IW_reg_en,
    output logic [2:0]  IW_writeregsel,
    output logic [15:0] IW_data,
    output logic        IW_HALT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Counter value in the 15th consecutive WAIT cycle without ack.
    localparam logic [3:0] TIMEOUT_TC = 4'd14;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        lat_reg_en, lat_reg_en_n;
    logic [2:0]  lat_sel, lat_sel_n;

    logic        req_n, wr_n, err_n;
    logic [15:0] addr_n, wdata_n;
    logic        iw_valid_n, iw_reg_en_n, iw_halt_n;
    logic [2:0]  iw_sel_n;
    logic [15:0] iw_data_n;
    logic        stall_c;
    logic        misaligned;

`ifdef MEM_ALIGN_CHK_EN
    assign misaligned = IM_alu_result[0];
`else
    assign misaligned = 1'b0;
`endif

    // Stall is held low for the whole time reset is asserted, even before
    // the reset edge has returned the FSM to IDLE.
    assign stall = stall_c & rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            cnt            <= 4'd0;
            lat_reg_en     <= 1'b0;
            lat_sel        <= 3'd0;
            mem_req        <= 1'b0;
            mem_wr         <= 1'b0;
            mem_addr       <= 16'd0;
            mem_wdata      <= 16'd0;
            err            <= 1'b0;
            IW_valid       <= 1'b0;
            IW_reg_en      <= 1'b0;
            IW_writeregsel <= 3'd0;
            IW_data        <= 16'd0;
            IW_HALT        <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            lat_reg_en     <= lat_reg_en_n;
            lat_sel        <= lat_sel_n;
            mem_req        <= req_n;
            mem_wr         <= wr_n;
            mem_addr       <= addr_n;
            mem_wdata      <= wdata_n;
            err            <= err_n;
            IW_valid       <= iw_valid_n;
            IW_reg_en      <= iw_reg_en_n;
            IW_writeregsel <= iw_sel_n;
            IW_data        <= iw_data_n;
            IW_HALT        <= iw_halt_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        lat_reg_en_n = lat_reg_en;
        lat_sel_n    = lat_sel;
        req_n        = mem_req;
        wr_n         = mem_wr;
        addr_n       = mem_addr;
        wdata_n      = mem_wdata;
        err_n        = err;
        iw_valid_n   = 1'b0;
        iw_reg_en_n  = 1'b0;
        iw_halt_n    = 1'b0;
        iw_sel_n     = IW_writeregsel;
        iw_data_n    = IW_data;
        stall_c      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (IM_valid) begin
                    if (IM_HALT) begin
                        iw_valid_n = 1'b1;
                        iw_halt_n  = 1'b1;
                        state_n    = ST_HALTED;
                    end else if (IM_mem_en) begin
                        if (misaligned) begin
                            // Refused access: let the pipeline advance so
                            // the instruction retires as a bubble.
                            err_n = 1'b1;
                        end else begin
                            stall_c      = 1'b1;
                            req_n        = 1'b1;
                            wr_n         = IM_mem_wr;
                            addr_n       = IM_alu_result;
                            wdata_n      = IM_r2;
                            lat_sel_n    = IM_writeregsel;
                            lat_reg_en_n = IM_reg_en;
                            cnt_n        = 4'd0;
                            state_n      = ST_WAIT;
                        end
                    end else begin
                        iw_valid_n  = 1'b1;
                        iw_reg_en_n = IM_reg_en;
                        iw_sel_n    = IM_writeregsel;
                        iw_data_n   = IM_alu_result;
                    end
                end
            end

            ST_WAIT: begin
                if (mem_ack) begin
                    req_n       = 1'b0;
                    wr_n        = 1'b0;
                    iw_valid_n  = 1'b1;
                    iw_sel_n    = lat_sel;
                    iw_reg_en_n = mem_wr ? 1'b0 : lat_reg_en;
                    if (!mem_wr) begin
                        iw_data_n = mem_rdata;
                    end
                    state_n     = ST_IDLE;
                end else if (cnt == TIMEOUT_TC) begin
                    // Timeout retires the op as a bubble. Stall drops in this
                    // cycle, as it does on an ack, so IM advances past the
                    // failed op instead of reissuing it from IDLE.
                    req_n   = 1'b0;
                    wr_n    = 1'b0;
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_n   = cnt + 4'd1;
                end
            end

            ST_HALTED: begin
                stall_c = 1'b1;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
